// File: rtl/onewire_rom_layer.sv
// onewire_rom_layer: 1-Wire slave ROM-command layer (Read/Match/Skip ROM), forwards function bytes once selected
// Ports: clk, reset (async active-low); wire_reset bus-reset pulse; rx_byte/rx_done from byte stage;
//        tx_byte/tx_dir/tx_load to byte stage; fn_byte/fn_valid/selected to application; rom_crc ROM byte 7
module onewire_rom_layer #(
    parameter logic [7:0]  FAMILY = 8'h02,
    parameter logic [47:0] SERIAL = 48'h0000_0001_B81C
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wire_reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    output logic [7:0] tx_byte,
    output logic       tx_dir,
    output logic       tx_load,
    output logic [7:0] fn_byte,
    output logic       fn_valid,
    output logic       selected,
    output logic [7:0] rom_crc
);
    typedef enum logic [2:0] {IDLE, ROM_CMD, READ_ROM, MATCH_ROM, SELECTED, UNSELECTED} state_t;
    state_t      r_state, w_state;
    logic [7:0]  r_crc;
    logic [55:0] r_sr;
    logic [5:0]  r_cnt;
    logic        r_rx_d1, r_rx_d2, w_rx_evt;
    logic [2:0]  r_idx, w_idx, w_idx_inc;
    logic [7:0]  w_tx_byte, w_fn_byte, w_rom_cur, w_rom_nxt;
    logic        w_tx_dir, w_tx_load, w_fn_valid, w_sel;
    logic [63:0] w_rom;
    // CRC is only published once all 56 ROM bits have been shifted through
    assign rom_crc   = (r_cnt == 6'd56) ? r_crc : 8'h00;
    assign w_rom     = {rom_crc, SERIAL, FAMILY};
    assign w_idx_inc = r_idx + 3'd1;
    assign w_rom_cur = w_rom[{r_idx, 3'b000} +: 8];
    assign w_rom_nxt = w_rom[{w_idx_inc, 3'b000} +: 8];
    // rx_done is sampled once, then edge-detected against its delayed copy
    assign w_rx_evt  = r_rx_d1 & ~r_rx_d2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc <= 8'h00;
            r_sr  <= {SERIAL, FAMILY};
            r_cnt <= 6'd0;
        end else if (r_cnt != 6'd56) begin
            r_crc <= (r_crc >> 1) ^ ({8{r_crc[0] ^ r_sr[0]}} & 8'h8C);
            r_sr  <= r_sr >> 1;
            r_cnt <= r_cnt + 6'd1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rx_d1  <= 1'b0;
            r_rx_d2  <= 1'b0;
            r_idx    <= 3'd0;
            tx_byte  <= 8'h00;
            tx_dir   <= 1'b0;
            tx_load  <= 1'b0;
            fn_byte  <= 8'h00;
            fn_valid <= 1'b0;
            selected <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_rx_d1  <= rx_done;
            r_rx_d2  <= r_rx_d1;
            r_idx    <= w_idx;
            tx_byte  <= w_tx_byte;
            tx_dir   <= w_tx_dir;
            tx_load  <= w_tx_load;
            fn_byte  <= w_fn_byte;
            fn_valid <= w_fn_valid;
            selected <= w_sel;
        end
    end
    always_comb begin
        w_state    = r_state;
        w_idx      = r_idx;
        w_tx_byte  = tx_byte;
        w_tx_dir   = tx_dir;
        w_tx_load  = 1'b0;
        w_fn_byte  = fn_byte;
        w_fn_valid = 1'b0;
        w_sel      = selected;
        // a bus reset wins over a same-cycle byte, which is dropped
        if (wire_reset) begin
            w_state  = ROM_CMD;
            w_tx_dir = 1'b0;
            w_sel    = 1'b0;
            w_idx    = 3'd0;
        end else if (w_rx_evt) begin
            case (r_state)
                ROM_CMD: begin
                    w_idx = 3'd0;
                    if (rx_byte == 8'h33) begin
                        w_state   = READ_ROM;
                        w_tx_byte = FAMILY;
                        w_tx_dir  = 1'b1;
                        w_tx_load = 1'b1;
                    end else if (rx_byte == 8'h55) begin
                        w_state = MATCH_ROM;
                    end else if (rx_byte == 8'hCC) begin
                        w_state = SELECTED;
                        w_sel   = 1'b1;
                    end else begin
                        w_state = UNSELECTED;
                    end
                end
                READ_ROM: begin
                    if (r_idx == 3'd7) begin
                        w_state  = SELECTED;
                        w_tx_dir = 1'b0;
                        w_sel    = 1'b1;
                    end else begin
                        w_idx     = w_idx_inc;
                        w_tx_byte = w_rom_nxt;
                        w_tx_load = 1'b1;
                    end
                end
                MATCH_ROM: begin
                    if (rx_byte != w_rom_cur) begin
                        w_state = UNSELECTED;
                    end else if (r_idx == 3'd7) begin
                        w_state = SELECTED;
                        w_sel   = 1'b1;
                    end else begin
                        w_idx = w_idx_inc;
                    end
                end
                SELECTED: begin
                    w_fn_byte  = rx_byte;
                    w_fn_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_onewire_rom_layer.sv
// tb_onewire_rom_layer: table-driven directed bench for onewire_rom_layer
module tb_onewire_rom_layer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wire_reset = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] tx_byte, fn_byte, rom_crc;
    logic       tx_dir, tx_load, fn_valid, selected;
    int         n_cmp = 0;
    int         n_err = 0;
    onewire_rom_layer dut (
        .clk(clk), .reset(reset), .wire_reset(wire_reset), .rx_byte(rx_byte), .rx_done(rx_done),
        .tx_byte(tx_byte), .tx_dir(tx_dir), .tx_load(tx_load), .fn_byte(fn_byte),
        .fn_valid(fn_valid), .selected(selected), .rom_crc(rom_crc)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic       wr;
        logic [7:0] rx;
        logic       ld;
        logic [7:0] txb;
        logic       dir;
        logic       fv;
        logic [7:0] fnb;
        logic       sel;
    } vec_t;
    vec_t vecs[$];
    function automatic vec_t mk(logic wr, logic [7:0] rx, logic ld, logic [7:0] txb, logic dir,
                                logic fv, logic [7:0] fnb, logic sel);
        vec_t v;
        v.wr = wr; v.rx = rx; v.ld = ld; v.txb = txb; v.dir = dir; v.fv = fv; v.fnb = fnb; v.sel = sel;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic pulse_wr();
        wire_reset = 1'b1;
        @(posedge clk); #1;
        wire_reset = 1'b0;
    endtask
    task automatic apply(input vec_t t, input int k);
        logic       c_ld, c_dir, c_fv, c_sel, p_ld, p_fv;
        logic [7:0] c_txb, c_fnb;
        if (t.wr) begin
            pulse_wr();
            chk($sformatf("v%0d_wr_sel", k), selected, 1'b0);
            chk($sformatf("v%0d_wr_dir", k), tx_dir, 1'b0);
        end
        rx_byte = t.rx;
        rx_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        c_ld = tx_load; c_txb = tx_byte; c_dir = tx_dir; c_fv = fn_valid; c_fnb = fn_byte; c_sel = selected;
        rx_done = 1'b0;
        @(posedge clk); #1;
        p_ld = tx_load; p_fv = fn_valid;
        chk($sformatf("v%0d_tx_load", k), c_ld, t.ld);
        if (t.ld) chk($sformatf("v%0d_tx_byte", k), c_txb, t.txb);
        chk($sformatf("v%0d_tx_dir", k), c_dir, t.dir);
        chk($sformatf("v%0d_fn_valid", k), c_fv, t.fv);
        if (t.fv) chk($sformatf("v%0d_fn_byte", k), c_fnb, t.fnb);
        chk($sformatf("v%0d_selected", k), c_sel, t.sel);
        chk($sformatf("v%0d_load_width", k), p_ld, 1'b0);
        chk($sformatf("v%0d_fv_width", k), p_fv, 1'b0);
    endtask
    task automatic chk_crc_release(input string nm);
        repeat (55) @(posedge clk);
        #1 chk({nm, "_crc_pending"}, rom_crc, 8'h00);
        @(posedge clk); #1;
        chk({nm, "_crc_final"}, rom_crc, 8'hA2);
    endtask
    task automatic chk_outputs_zero(input string nm);
        chk({nm, "_tx_byte"}, tx_byte, 8'h00);
        chk({nm, "_tx_dir"}, tx_dir, 1'b0);
        chk({nm, "_tx_load"}, tx_load, 1'b0);
        chk({nm, "_fn_byte"}, fn_byte, 8'h00);
        chk({nm, "_fn_valid"}, fn_valid, 1'b0);
        chk({nm, "_selected"}, selected, 1'b0);
        chk({nm, "_rom_crc"}, rom_crc, 8'h00);
    endtask
    initial begin
        int fv_cnt;
        vecs.push_back(mk(0, 8'h33, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h33, 1, 8'h02, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h1C, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'hB8, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h01, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h00, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h00, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h00, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'hA2, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'h44, 0, 8'h00, 0, 1, 8'h44, 1));
        vecs.push_back(mk(1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h02, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h1C, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hB8, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h01, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hA2, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'h44, 0, 8'h00, 0, 1, 8'h44, 1));
        vecs.push_back(mk(1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h02, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h1C, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h44, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'hCC, 0, 8'h00, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 8'hBE, 0, 8'h00, 0, 1, 8'hBE, 1));
        vecs.push_back(mk(1, 8'hF0, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'h44, 0, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1, 8'h33, 1, 8'h02, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h1C, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'hB8, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 8'hFF, 1, 8'h01, 1, 0, 8'h00, 0));
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        reset = 1'b1;
        chk_crc_release("init");
        foreach (vecs[i]) apply(vecs[i], i);
        // bus reset in the same cycle as a read-slot byte event: byte is dropped
        rx_byte = 8'hFF;
        rx_done = 1'b1;
        @(posedge clk); #1;
        wire_reset = 1'b1;
        @(posedge clk); #1;
        chk("wr_evt_tx_load", tx_load, 1'b0);
        chk("wr_evt_tx_dir", tx_dir, 1'b0);
        chk("wr_evt_selected", selected, 1'b0);
        wire_reset = 1'b0;
        rx_done = 1'b0;
        @(posedge clk); #1;
        chk("wr_evt_tx_load_late", tx_load, 1'b0);
        apply(mk(0, 8'h33, 1, 8'h02, 1, 0, 8'h00, 0), 100);
        apply(mk(1, 8'hCC, 0, 8'h00, 0, 0, 8'h00, 1), 101);
        apply(mk(0, 8'hBE, 0, 8'h00, 0, 1, 8'hBE, 1), 102);
        // a long rx_done level must yield a single byte event
        rx_byte = 8'h5A;
        rx_done = 1'b1;
        fv_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (fv_cnt == 0 && fn_valid) chk("hold_fn_byte", fn_byte, 8'h5A);
            if (fn_valid) fv_cnt++;
        end
        rx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (fn_valid) fv_cnt++;
        end
        chk("hold_one_evt", fv_cnt, 1);
        chk("hold_tx_byte_kept", tx_byte, 8'h02);
        // async reset in SELECTED clears everything without a clock edge
        reset = 1'b0;
        #2 chk_outputs_zero("async");
        @(posedge clk); #1;
        reset = 1'b1;
        chk_crc_release("rerelease");
        apply(mk(0, 8'hCC, 0, 8'h00, 0, 0, 8'h00, 0), 103);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/onewire_rom_layer.md
# onewire_rom_layer

ROM-command (network) layer of the 1-Wire slave, directly downstream of the bit/byte-level slave stage. It consumes received bytes and bus-reset events from that stage and decodes the ROM command (Read ROM, Match ROM, Skip ROM). It drives the stage's transmit controls to return the 64-bit ROM code, and once the device is selected it forwards function-command bytes to the application logic above.

## Interface
- FAMILY, 8'h02, family code, ROM byte 0
- SERIAL, 48'h0000_0001_B81C, serial number, ROM bytes 1..6, LS byte first
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- wire_reset  input  1  one-cycle pulse from the byte stage when a 1-Wire bus reset is detected
- rx_byte  input  8  last received byte from the byte stage
- rx_done  input  1  byte-stage "finished" level; its rising edge marks a completed 8-slot byte, read or write
- tx_byte  output  8  byte to transmit, LSB first, to the byte stage's in_byte
- tx_dir  output  1  1 = slave drives read slots, to the byte stage's direction
- tx_load  output  1  one-cycle strobe latching tx_byte into the byte stage, to next_strobe
- fn_byte  output  8  function-command or data byte for the application
- fn_valid  output  1  one-cycle strobe qualifying fn_byte
- selected  output  1  device is addressed; function phase active
- rom_crc  output  8  Dallas CRC-8 of bytes 0..6, ROM byte 7

## Operation
- CRC engine:
  - Serial CRC-8, x^8+x^5+x^4+1, reflected, init 0x00, over the 56 bits {SERIAL, FAMILY}, LSB first.
  - Starts on reset release and shifts one bit per clk.
  - rom_crc is final 56 cycles after release and holds until the next reset.
- Byte event: rx_evt = rx_done rising edge, detected with a one-flop delay register.
- States: IDLE, ROM_CMD, READ_ROM, MATCH_ROM, SELECTED, UNSELECTED.
- IDLE: entered on reset. Waits for wire_reset; ignores rx_evt.
- wire_reset, in any state, goes to ROM_CMD and clears tx_dir, selected and the byte index. wire_reset has priority over a same-cycle rx_evt, and that byte is discarded.
- ROM_CMD, on rx_evt, dispatches on rx_byte:
  - 0x33 goes to READ_ROM. Sets tx_byte=FAMILY and tx_dir=1, pulses tx_load, index=0.
  - 0x55 goes to MATCH_ROM with index=0.
  - 0xCC goes to SELECTED.
  - Anything else goes to UNSELECTED.
- READ_ROM, on each rx_evt (a byte of read slots completed):
  - index++.
  - If index < 8, load ROM byte[index] with a tx_load pulse. Byte 7 = rom_crc.
  - After byte 7 completes, tx_dir=0 and go to SELECTED.
- MATCH_ROM, on each rx_evt:
  - Compare rx_byte with ROM byte[index].
  - Mismatch goes to UNSELECTED immediately.
  - Match on index 7 goes to SELECTED; otherwise index++.
- SELECTED:
  - selected=1.
  - Every rx_evt copies rx_byte to fn_byte and pulses fn_valid.
  - tx_dir stays 0; application transmit is out of scope.
- UNSELECTED: ignores all rx_evt until wire_reset.
- Reset mid-operation (async reset low): immediately goes to IDLE and all outputs take their reset values. A byte in flight is lost.

## Timing
- Reset values:
  - tx_byte=0, tx_dir=0, tx_load=0.
  - fn_byte=0, fn_valid=0, selected=0.
  - rom_crc=0 until the CRC completes.
  - state=IDLE.
- rx_evt is asserted the cycle after rx_done is first sampled high.
- Latency from rx_evt to any response is one clk:
  - tx_load/tx_byte/tx_dir, fn_valid/fn_byte, and selected all update the clk after rx_evt.
- tx_byte is stable from the tx_load cycle until the next tx_load.
- tx_load and fn_valid are exactly one clk wide and are never asserted in the same cycle.
- The rx_done level held high across multiple cycles produces exactly one rx_evt.
- selected falls the clk after wire_reset.

## Test plan
- Reset, then wire_reset, then rx byte 0x33, then 8 read-byte events -> tx_load pulses carry 0x02,0x1C,0xB8,0x01,0x00,0x00,0x00,0xA2; tx_dir=1 throughout, 0 after the last; selected=1.
- wire_reset, 0x55, then bytes 02 1C B8 01 00 00 00 A2, then 0x44 -> selected=1; fn_valid pulses once with fn_byte=0x44.
- wire_reset, 0x55, then 02 1C FF ... -> UNSELECTED after the third byte; a later 0x44 gives no fn_valid and selected=0.
- wire_reset, 0xCC, 0xBE -> selected=1 one clk after the 0xCC rx_evt; fn_byte=0xBE; unknown command 0xF0 -> no response.
- wire_reset asserted mid-READ_ROM (after 3 bytes) in the same cycle as rx_evt -> no tx_load; tx_dir=0; state ROM_CMD; next 0x33 restarts at 0x02.
- Async reset low during SELECTED -> all outputs 0 immediately; rom_crc=0xA2 again 56 clk after release.
